// File: rtl/if_fetch_buffer.sv
// Instruction-fetch buffer: issues in-order imem reads for pc_i and queues returned words for decode.
// Latency: accept in cycle N, response in cycle M>=N+1, instruction visible to decode in cycle M+1.
// Backpressure: no request while DEPTH entries are allocated; fetch_stall holds the PC until accept.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt event counters.
module if_fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc_i,
   input  logic        pc_redirect,
   output logic [31:0] pre_pc,
   output logic        fetch_stall,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_drop_cnt
`endif
);

   localparam logic [PTR_W:0]   DEPTH_P  = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W+1:0] DEPTH_W  = (PTR_W + 2)'(DEPTH);

   // Entry storage: PC captured at request, instruction and filled flag at response.
   logic [31:0]      pc_q     [DEPTH];
   logic [31:0]      instr_q  [DEPTH];
   logic [DEPTH-1:0] filled_q;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0] alloc_q, alloc_d;
   logic [PTR_W:0] fill_q,  fill_d;
   logic [PTR_W:0] head_q,  head_d;
   logic [PTR_W:0] cnt_q,   cnt_d;
   logic [PTR_W:0] drop_q,  drop_d;

   logic [PTR_W-1:0] alloc_idx;
   logic [PTR_W-1:0] fill_idx;
   logic [PTR_W-1:0] head_idx;
   logic [PTR_W:0]   outstanding;
   logic             flush;
   logic             accept;
   logic             resp_fill;
   logic             resp_drop;
   logic             pop;
   logic [PTR_W+1:0] drop_sum;

   assign alloc_idx   = alloc_q[PTR_W-1:0];
   assign fill_idx    = fill_q[PTR_W-1:0];
   assign head_idx    = head_q[PTR_W-1:0];
   // Requests issued by the live buffer that have not yet returned.
   assign outstanding = alloc_q - fill_q;
   assign flush       = pc_redirect;

   // PC-generator side: sequential next PC and the aligned request address.
   assign pre_pc         = pc_i + 32'h4;
   assign imem_req_addr  = {pc_i[31:2], 2'b00};
   // A freed slot is not reused in the same cycle, so only cnt_q gates the request.
   assign imem_req_valid = reset_n & ~flush & (cnt_q < DEPTH_P);
   assign accept         = imem_req_valid & imem_req_ready;
   assign fetch_stall    = ~accept;

   // Decode side: head entry is presented once its instruction has returned.
   assign if_valid = filled_q[head_idx] & (cnt_q != '0);
   assign if_pc    = pc_q[head_idx];
   assign if_instr = instr_q[head_idx];
   assign pop      = if_valid & if_ready & ~flush;

   // Response routing: wrong-path returns are swallowed before any live entry is filled.
   // A response with nothing outstanding is a protocol error and is simply ignored.
   assign resp_drop = imem_resp_valid & ~flush & (drop_q != '0);
   assign resp_fill = imem_resp_valid & ~flush & (drop_q == '0) & (outstanding != '0);

   // Next-state for pointers, occupancy and the discard counter; redirect overrides everything.
   always_comb begin
      alloc_d  = alloc_q;
      fill_d   = fill_q;
      head_d   = head_q;
      cnt_d    = cnt_q;
      drop_d   = drop_q;
      drop_sum = '0;
      if (flush) begin
         // Everything still in flight for the old path becomes a discard; a response
         // landing this very cycle retires one of them immediately.
         drop_sum = {1'b0, drop_q} + {1'b0, outstanding};
         if (imem_resp_valid && (drop_sum != '0)) begin
            drop_sum = drop_sum - 1'b1;
         end
         if (drop_sum > DEPTH_W) begin
            drop_d = DEPTH_P;
         end else begin
            drop_d = drop_sum[PTR_W:0];
         end
         head_d = alloc_q;
         fill_d = alloc_q;
         cnt_d  = '0;
      end else begin
         if (accept) begin
            alloc_d = alloc_q + 1'b1;
         end
         if (resp_fill) begin
            fill_d = fill_q + 1'b1;
         end
         if (resp_drop) begin
            drop_d = drop_q - 1'b1;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end
         case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer, occupancy and discard-counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alloc_q <= '0;
         fill_q  <= '0;
         head_q  <= '0;
         cnt_q   <= '0;
         drop_q  <= '0;
      end else begin
         alloc_q <= alloc_d;
         fill_q  <= fill_d;
         head_q  <= head_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   // Entry payload: capture PC on accept, instruction on a live response, clear all on redirect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
         filled_q <= '0;
      end else if (flush) begin
         filled_q <= '0;
      end else begin
         // alloc and fill slots never coincide: that would need DEPTH outstanding, which blocks accept.
         if (accept) begin
            pc_q[alloc_idx]     <= pc_i;
            filled_q[alloc_idx] <= 1'b0;
         end
         if (resp_fill) begin
            instr_q[fill_idx]  <= imem_resp_data;
            filled_q[fill_idx] <= 1'b1;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic        resp_discard;
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_drop_q;

   // A response is discarded when old-path returns are pending or the redirect cycle owns it.
   assign resp_discard = imem_resp_valid & ((drop_q != '0) | (flush & (outstanding != '0)));

   // Free-running event counters, wrapping at 2^32.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetch_q <= '0;
         perf_drop_q  <= '0;
      end else begin
         if (accept) begin
            perf_fetch_q <= perf_fetch_q + 32'd1;
         end
         if (resp_discard) begin
            perf_drop_q <= perf_drop_q + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: per-cycle vector table plus reset corner sequences.
// Inputs driven 1 time unit after the rising edge, outputs checked on the falling edge.
// Memory responses are scripted in the table so every expected value is hand-computed.
module tb_if_fetch_buffer;

   logic        clk;
   logic        reset_n;
   logic [31:0] pc_i;
   logic        pc_redirect;
   logic [31:0] pre_pc;
   logic        fetch_stall;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_drop_cnt;
`endif

   int total;
   int bad;

   if_fetch_buffer #(.DEPTH(2), .PTR_W(1)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .pc_i            (pc_i),
      .pc_redirect     (pc_redirect),
      .pre_pc          (pre_pc),
      .fetch_stall     (fetch_stall),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_pc           (if_pc),
      .if_instr        (if_instr)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_drop_cnt   (perf_drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        redir;
      logic        rrdy;
      logic        rspv;
      logic [31:0] rspd;
      logic        ifrdy;
      logic        exp_reqv;
      logic        exp_stall;
      logic        exp_ifv;
      logic [31:0] exp_ifpc;
      logic [31:0] exp_ifin;
   } vec_t;

   vec_t tbl [30];

   function automatic vec_t mk(input logic [31:0] pc, input logic redir, input logic rrdy,
                               input logic rspv, input logic [31:0] rspd, input logic ifrdy,
                               input logic reqv, input logic stall, input logic ifv,
                               input logic [31:0] ifpc, input logic [31:0] ifin);
      vec_t v;
      v.pc = pc; v.redir = redir; v.rrdy = rrdy; v.rspv = rspv; v.rspd = rspd; v.ifrdy = ifrdy;
      v.exp_reqv = reqv; v.exp_stall = stall; v.exp_ifv = ifv; v.exp_ifpc = ifpc; v.exp_ifin = ifin;
      return v;
   endfunction

   function automatic logic [31:0] d(input int k);
      return 32'hC0DE_0000 + 32'(k);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check at the falling edge, then advance past the next rising edge.
   task automatic apply(input vec_t v, input string tag);
      pc_i            = v.pc;
      pc_redirect     = v.redir;
      imem_req_ready  = v.rrdy;
      imem_resp_valid = v.rspv;
      imem_resp_data  = v.rspd;
      if_ready        = v.ifrdy;
      @(negedge clk);
      chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(v.exp_reqv));
      chk({tag, " fetch_stall"}, 32'(fetch_stall), 32'(v.exp_stall));
      chk({tag, " if_valid"}, 32'(if_valid), 32'(v.exp_ifv));
      chk({tag, " pre_pc"}, pre_pc, v.pc + 32'h4);
      if (v.exp_reqv) chk({tag, " req_addr"}, imem_req_addr, {v.pc[31:2], 2'b00});
      if (v.exp_ifv) begin
         chk({tag, " if_pc"}, if_pc, v.exp_ifpc);
         chk({tag, " if_instr"}, if_instr, v.exp_ifin);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;

      //          pc        rd rr rv data   ir | reqv stall ifv if_pc     if_instr
      // in-order streaming with a 1-cycle memory
      tbl[0]  = mk(32'h000, 0, 1, 0, 0,     1,   1, 0, 0, 0,        0);
      tbl[1]  = mk(32'h004, 0, 1, 1, d(0),  1,   1, 0, 0, 0,        0);
      tbl[2]  = mk(32'h008, 0, 1, 1, d(1),  1,   0, 1, 1, 32'h000,  d(0));
      tbl[3]  = mk(32'h008, 0, 1, 0, 0,     1,   1, 0, 1, 32'h004,  d(1));
      tbl[4]  = mk(32'h00C, 0, 1, 1, d(2),  1,   1, 0, 0, 0,        0);
      tbl[5]  = mk(32'h010, 0, 1, 1, d(3),  1,   0, 1, 1, 32'h008,  d(2));
      // decode backpressure: buffer fills, one pop, request resumes next cycle
      tbl[6]  = mk(32'h010, 0, 1, 0, 0,     0,   1, 0, 1, 32'h00C,  d(3));
      tbl[7]  = mk(32'h014, 0, 1, 1, d(4),  0,   0, 1, 1, 32'h00C,  d(3));
      tbl[8]  = mk(32'h014, 0, 1, 0, 0,     0,   0, 1, 1, 32'h00C,  d(3));
      tbl[9]  = mk(32'h014, 0, 1, 0, 0,     1,   0, 1, 1, 32'h00C,  d(3));
      tbl[10] = mk(32'h014, 0, 1, 0, 0,     0,   1, 0, 1, 32'h010,  d(4));
      // memory not ready: PC held, no allocation
      tbl[11] = mk(32'h018, 0, 0, 1, d(5),  1,   0, 1, 1, 32'h010,  d(4));
      tbl[12] = mk(32'h018, 0, 0, 0, 0,     1,   1, 1, 1, 32'h014,  d(5));
      tbl[13] = mk(32'h018, 0, 0, 0, 0,     1,   1, 1, 0, 0,        0);
      tbl[14] = mk(32'h018, 0, 0, 0, 0,     1,   1, 1, 0, 0,        0);
      // two outstanding, redirect to 0x100, two stale responses discarded
      tbl[15] = mk(32'h018, 0, 1, 0, 0,     1,   1, 0, 0, 0,        0);
      tbl[16] = mk(32'h01C, 0, 1, 0, 0,     1,   1, 0, 0, 0,        0);
      tbl[17] = mk(32'h100, 1, 1, 0, 0,     1,   0, 1, 0, 0,        0);
      tbl[18] = mk(32'h100, 0, 1, 1, d(6),  1,   1, 0, 0, 0,        0);
      tbl[19] = mk(32'h104, 0, 1, 1, d(7),  1,   1, 0, 0, 0,        0);
      tbl[20] = mk(32'h108, 0, 1, 1, d(8),  1,   0, 1, 0, 0,        0);
      tbl[21] = mk(32'h108, 0, 1, 0, 0,     1,   0, 1, 1, 32'h100,  d(8));
      // redirect coincident with a response: 2 allocated, 1 filled, nothing left to drop
      tbl[22] = mk(32'h108, 0, 1, 0, 0,     0,   1, 0, 0, 0,        0);
      tbl[23] = mk(32'h10C, 0, 1, 1, d(9),  0,   0, 1, 0, 0,        0);
      tbl[24] = mk(32'h200, 1, 1, 1, d(10), 0,   0, 1, 1, 32'h104,  d(9));
      tbl[25] = mk(32'h200, 0, 1, 0, 0,     1,   1, 0, 0, 0,        0);
      tbl[26] = mk(32'h204, 0, 1, 1, d(11), 1,   1, 0, 0, 0,        0);
      tbl[27] = mk(32'h208, 0, 1, 1, d(12), 1,   0, 1, 1, 32'h200,  d(11));
      tbl[28] = mk(32'h208, 0, 1, 0, 0,     1,   1, 0, 1, 32'h204,  d(12));
      tbl[29] = mk(32'h20C, 0, 1, 1, d(13), 1,   1, 0, 0, 0,        0);

      // Reset state and combinational next-PC wrap.
      reset_n         = 1'b0;
      pc_i            = 32'hFFFF_FFFC;
      pc_redirect     = 1'b0;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if_ready        = 1'b1;
      @(negedge clk);
      chk("rst req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst fetch_stall", 32'(fetch_stall), 32'h1);
      chk("rst if_valid", 32'(if_valid), 32'h0);
      chk("rst if_pc", if_pc, 32'h0);
      chk("rst if_instr", if_instr, 32'h0);
      chk("pre_pc wrap", pre_pc, 32'h0000_0000);
      pc_i = 32'h7FFF_FFFC;
      #1;
      chk("pre_pc carry", pre_pc, 32'h8000_0000);
`ifdef FETCH_PERF_CNT_EN
      chk("rst perf_fetch", perf_fetch_cnt, 32'h0);
      chk("rst perf_drop", perf_drop_cnt, 32'h0);
`endif
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      for (int i = 0; i < 30; i++) begin
`ifdef FETCH_PERF_CNT_EN
         if (i == 21) begin
            chk("perf_fetch after redirect", perf_fetch_cnt, 32'd10);
            chk("perf_drop after redirect", perf_drop_cnt, 32'd2);
         end
`endif
         apply(tbl[i], $sformatf("vec%0d", i));
      end

`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch final", perf_fetch_cnt, 32'd15);
      chk("perf_drop final", perf_drop_cnt, 32'd3);
`endif

      // Reset asserted mid-cycle with requests in flight: state clears immediately.
      pc_i            = 32'h300;
      pc_redirect     = 1'b0;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      if_ready        = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst req_valid", 32'(imem_req_valid), 32'h0);
      chk("midrst fetch_stall", 32'(fetch_stall), 32'h1);
      chk("midrst if_valid", 32'(if_valid), 32'h0);
      chk("midrst if_pc", if_pc, 32'h0);
      chk("midrst if_instr", if_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("midrst perf_fetch", perf_fetch_cnt, 32'h0);
`endif
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      apply(mk(32'h300, 0, 1, 0, 0,      0, 1, 0, 0, 0,       0),      "post0");
      apply(mk(32'h304, 0, 1, 1, d(14),  0, 1, 0, 0, 0,       0),      "post1");
      apply(mk(32'h308, 0, 1, 0, 0,      1, 0, 1, 1, 32'h300, d(14)),  "post2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
